modcounter: RTL

Parametrised loadable up/down modulo counter; next-generation replacement for the fixed 3-bit loadable incrementer. Adds configurable width and terminal value, decrement, wrap-or-saturate mode, terminal-count and overflow reporting, and rejection of out-of-range loads. Used as a building block for timers, address generators and event counters; carries its own protocol-check sub-module, removable with the `ASSERTIONS_OFF` define.

---
 rtl/counter_pkg.sv | 38 +++
 rtl/modcounter_firewall.sv | 62 ++++++
 rtl/modcounter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
//------------------------------------------------------------------------------
// Module      : counter_pkg
// Description : Shared constants, command encoding and decode helper for the
//               loadable modulo counter family.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    typedef enum logic [1:0] {
        CMD_HOLD = 2'd0,
        CMD_LD   = 2'd1,
        CMD_INC  = 2'd2,
        CMD_DEC  = 2'd3
    } cmd_e;

    // Rejected loads and inc+dec collisions both collapse to a hold.
    function automatic cmd_e cmd_decode(input logic ld, input logic ld_ok,
                                        input logic inc, input logic dec);
        cmd_e cmd;
        cmd = CMD_HOLD;
        if (ld) begin
            cmd = ld_ok ? CMD_LD : CMD_HOLD;
        end else if (inc && !dec) begin
            cmd = CMD_INC;
        end else if (dec && !inc) begin
            cmd = CMD_DEC;
        end
        return cmd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/modcounter_firewall.sv
//------------------------------------------------------------------------------
// Module      : modcounter_firewall
// Description : Protocol and invariant checker attached to modcounter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module modcounter_firewall
    import counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 2**WIDTH-1,
    parameter int SATURATE  = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] data_out,
    input  logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL = MAX_COUNT[WIDTH-1:0];
    localparam bit PARAMS_OK = (WIDTH >= 2) && (WIDTH <= 31) && (MAX_COUNT >= 1)
                               && (MAX_COUNT <= 2**WIDTH-1)
                               && ((SATURATE == CNT_WRAP) || (SATURATE == CNT_SAT));

    logic boundary_d;
    logic boundary_q;

    // A legal tc always traces back to an unambiguous step off a range end.
    always_comb begin
        boundary_d = !rst && !ld && (inc != dec)
                     && ((inc && (data_out == MAX_VAL)) || (dec && (data_out == '0)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            boundary_q <= 1'b0;
        end else begin
            boundary_q <= boundary_d;
        end
    end

    always_ff @(posedge clk) begin
        assert (PARAMS_OK)
            else $error("modcounter_firewall: illegal parameters WIDTH=%0d MAX_COUNT=%0d SATURATE=%0d",
                        WIDTH, MAX_COUNT, SATURATE);
        if (!rst) begin
            assert (!$isunknown({ld, inc, dec}))
                else $error("modcounter_firewall: X/Z on ld/inc/dec");
            assert (data_out <= MAX_VAL)
                else $error("modcounter_firewall: data_out %0d above MAX_COUNT", data_out);
            assert (!tc || boundary_q)
                else $error("modcounter_firewall: tc without boundary condition");
        end
    end

endmodule

`default_nettype wire

// File: rtl/modcounter.sv
//------------------------------------------------------------------------------
// Module      : modcounter
// Description : Parametrised loadable up/down modulo counter with wrap or
//               saturate mode, terminal-count, overflow and load-error flags.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module modcounter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 2**WIDTH-1,
    parameter int SATURATE  = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr_ovf,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             tc,
    output logic             ovf,
    output logic             ld_err,
    output logic             at_zero,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_VAL = MAX_COUNT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam bit               SAT_EN  = (SATURATE == CNT_SAT);

    logic [WIDTH-1:0] cnt_d, cnt_q;
    logic             tc_d, tc_q;
    logic             ovf_d, ovf_q;
    logic             ld_err_d, ld_err_q;
    logic             ld_ok;
    cmd_e             cmd;

    always_comb begin
        ld_ok    = (data_in <= MAX_VAL);
        cmd      = cmd_decode(ld, ld_ok, inc, dec);
        cnt_d    = cnt_q;
        tc_d     = 1'b0;
        ld_err_d = ld && !ld_ok;
        ovf_d    = ovf_q && !clr_ovf;

        case (cmd)
            CMD_LD: begin
                cnt_d = data_in;
            end
            CMD_INC: begin
                if (cnt_q == MAX_VAL) begin
                    tc_d  = 1'b1;
                    cnt_d = SAT_EN ? cnt_q : '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            CMD_DEC: begin
                if (cnt_q == '0) begin
                    tc_d  = 1'b1;
                    cnt_d = SAT_EN ? cnt_q : MAX_VAL;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase

        // A new boundary event outranks a same-cycle clear.
        if (tc_d) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            tc_q     <= 1'b0;
            ovf_q    <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            tc_q     <= tc_d;
            ovf_q    <= ovf_d;
            ld_err_q <= ld_err_d;
        end
    end

    assign data_out = cnt_q;
    assign tc       = tc_q;
    assign ovf      = ovf_q;
    assign ld_err   = ld_err_q;
    assign at_zero  = (cnt_q == '0);
    assign at_max   = (cnt_q == MAX_VAL);

`ifndef ASSERTIONS_OFF
    modcounter_firewall #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT),
        .SATURATE  (SATURATE)
    ) u_firewall (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .inc      (inc),
        .dec      (dec),
        .data_out (cnt_q),
        .tc       (tc_q)
    );
`endif

endmodule

`default_nettype wire
